// File: rtl/parity_sched_pkg.sv
// parity_sched_pkg: shared state types and width helper for the parity frame scheduler.
package parity_sched_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} sched_state_e;
   typedef enum logic {EVEN, ODD} par_state_e;
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/parity_bit_core.sv
// parity_bit_core: Moore bit-serial parity detector; det_out is 1 while an even number of ones has been seen.
module parity_bit_core
   import parity_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic seq_in,
   output logic det_out
);
   par_state_e state_q, state_d;
   always_comb begin
      state_d = clr ? EVEN : (seq_in ? ((state_q == EVEN) ? ODD : EVEN) : state_q);
   end
   always_ff @(posedge clk) begin
      if (rst) state_q <= EVEN;
      else     state_q <= state_d;
   end
   assign det_out = (state_q == EVEN);
endmodule

// File: rtl/parity_frame_sched.sv
// parity_frame_sched: round-robin arbiter feeding one word at a time, LSB first, into a shared parity core.
module parity_frame_sched
   import parity_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]     req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rsp_valid,
   output logic [clog2w(NUM_REQ)-1:0]   rsp_id,
   output logic                         rsp_even,
   input  logic                         rsp_ready
);
   localparam int ID_W  = clog2w(NUM_REQ);
   localparam int CNT_W = clog2w(WIDTH);
   sched_state_e     state_q, state_d;
   logic [ID_W-1:0]  last_q, last_d, id_q, id_d, win, cand;
   logic [WIDTH-1:0] shift_q, shift_d, sel;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             found, xfer, seq_in, det_out;
   // Scan from farthest to nearest so the requester closest after last_q wins.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      sel   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last_q) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (win == ID_W'(i)) sel = req_data[i*WIDTH +: WIDTH];
   end
   always_comb begin
      xfer      = (state_q == IDLE) && found;
      req_ready = xfer ? (NUM_REQ'(1) << win) : '0;
      state_d   = (state_q == IDLE)  ? (found ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? ((cnt_q == CNT_W'(WIDTH-1)) ? REPORT : SHIFT) :
                                       (rsp_ready ? IDLE : REPORT);
      shift_d   = xfer ? sel : ((state_q == SHIFT) ? (shift_q >> 1) : shift_q);
      cnt_d     = xfer ? '0 : ((state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q);
      id_d      = xfer ? win : id_q;
      last_d    = ((state_q == REPORT) && rsp_ready) ? id_q : last_q;
      seq_in    = (state_q == SHIFT) && shift_q[0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= ID_W'(NUM_REQ-1);
         id_q    <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end
   parity_bit_core u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (xfer),
      .seq_in  (seq_in),
      .det_out (det_out)
   );
   assign rsp_valid = (state_q == REPORT);
   assign rsp_id    = id_q;
   assign rsp_even  = det_out;
endmodule
